alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Issue/writeback controller wrapped around the 8-bit ALU. It accepts one ALU instruction at a time over a valid/ready handshake and reads operands from a four-entry register file (R0–R3) that it owns. It drives the ALU operand/op/enable ports for one cycle, then captures the ALU result and flags and writes the result back to the destination register. The block sits between instruction decode (upstream) and the ALU (downstream), and also consumes the ALU's outputs.

## Interface
- No parameters; data width fixed at 8, register file fixed at 4 entries.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  high only in IDLE and reset deasserted
- in_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 ADC
- in_dst  in  2  destination register, also operand A source
- in_src  in  2  operand B register
- in_imm_en  in  1  1: operand B = in_imm; 0: operand B = R[in_src]
- in_imm  in  8  immediate operand
- ld_en, ld_sel[1:0], ld_data[7:0]  in  direct register-load port (init/test)
- rd_sel  in  2; rd_data  out  8  combinational read, rd_data = R[rd_sel]
- alu_enable  out  1  one-cycle pulse to ALU
- alu_op  out  3; alu_a, alu_b  out  8  registered ALU inputs
- alu_out  in  8; alu_zero, alu_carry  in  1  registered ALU outputs; valid the cycle after alu_enable is sampled high
- done  out  1  one-cycle pulse: writeback complete
- result  out  8  last written-back value
- flag_z, flag_c  out  1  flags captured at last writeback

## Operation
- States: IDLE, ISSUE, WB. Reset to IDLE.
- IDLE: in_ready=1. If in_valid, latch op, dst, alu_a=R[in_dst], alu_b=(in_imm_en ? in_imm : R[in_src]), then go to ISSUE. Operands are read with pre-edge register values.
- ISSUE: alu_enable=1 for exactly this cycle; alu_op/a/b stay stable. Go to WB.
- WB: alu_enable=0. At the closing edge: R[dst]<=alu_out, result<=alu_out, flag_z<=alu_zero, flag_c<=alu_carry, done<=1. Go to IDLE.
- flag_c is always taken from alu_carry, including for logic ops. The ALU holds its carry on logic ops, so the previous carry propagates.
- done is registered; it is high for the single cycle after WB and low otherwise.
- ld port: writes R[ld_sel]<=ld_data at any edge. If the same edge performs a WB writeback to the same register, the WB write wins and the ld write is dropped. A ld to a different register takes effect normally.
- INC/DEC ignore alu_b, but the controller still drives alu_b per in_imm_en.
- Reset values: R0–R3=0, alu_enable=0, alu_op=0, alu_a=alu_b=0, done=0, result=0, flag_z=0, flag_c=0. in_ready=0 while reset is high.
- Reset during ISSUE or WB: abandon the operation. No writeback, no done pulse; return to IDLE.

## Timing
- Cycle T: handshake (in_valid & in_ready) sampled at the edge ending T.
- T+1: ISSUE, alu_enable=1. The ALU registers its result at the edge ending T+1.
- T+2: WB. Writeback and flag capture happen at the edge ending T+2.
- T+3: done=1, result/flags/R[dst] updated, state IDLE, in_ready=1. A new instruction can be accepted in T+3.
- Throughput: one instruction every 3 cycles. Latency from accept to done: 3 cycles.
- in_valid while in_ready=0 is ignored; no queuing. Upstream must hold in_valid until accepted.
- A ld to an operand register in cycle T is not seen by that instruction; it uses the old value.

## Test plan
- Reset then idle: in_ready=1, all outputs 0, rd_data=0 for every rd_sel, no alu_enable activity.
- ld R0=0xF0, R1=0x20; issue ADD dst=0 src=1 -> alu_enable pulse at T+1 with alu_a=0xF0, alu_b=0x20; at T+3 done=1, result=0x10, flag_c=1, flag_z=0, R0=0x10.
- ld R2=0x01; issue SUB dst=2 imm_en=1 imm=0x01 -> result=0x00, flag_z=1, flag_c=0, R2=0x00. Then issue DEC dst=2 -> result=0xFF, flag_c=1.
- Back-to-back: hold in_valid high across two ADDs -> second accepted exactly at T+3, in_ready low during T+1..T+2, two done pulses 3 cycles apart.
- Collision: during WB of dst=3, drive ld_en with ld_sel=3, ld_data=0xAA -> R3 holds the ALU result, not 0xAA. Repeat with ld_sel=1 -> R1=0xAA.
- Reset asserted during ISSUE -> no done pulse, R[dst] unchanged (0 after reset), state IDLE, in_ready=1 after reset deasserts.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller for the 8-bit ALU: owns a 4-entry register file,
// issues one instruction at a time and writes the ALU result back 3 cycles after accept.
module alu_exec_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [1:0] in_dst,
  input  logic [1:0] in_src,
  input  logic       in_imm_en,
  input  logic [7:0] in_imm,
  input  logic       ld_en,
  input  logic [1:0] ld_sel,
  input  logic [7:0] ld_data,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       alu_enable,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      dst_q, dst_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic            done_q, done_d;
  logic [7:0]      result_q, result_d;
  logic            fz_q, fz_d, fc_q, fc_d;
  logic            accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE) && !reset;
    alu_enable = (state_q == ISSUE);
  end

  // Datapath next-state: operands latched at accept from pre-edge registers;
  // the WB write is applied after the ld write so it wins a same-register collision.
  always_comb begin
    op_d     = op_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    regs_d   = regs_q;
    done_d   = 1'b0;
    result_d = result_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    if (accept) begin
      op_d  = in_op;
      dst_d = in_dst;
      a_d   = regs_q[in_dst];
      b_d   = in_imm_en ? in_imm : regs_q[in_src];
    end
    if (ld_en) regs_d[ld_sel] = ld_data;
    if (state_q == WB) begin
      regs_d[dst_q] = alu_out;
      result_d      = alu_out;
      fz_d          = alu_zero;
      fc_d          = alu_carry;
      done_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q   <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      result_q <= result_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
    end
  end

  assign rd_data = regs_q[rd_sel];
  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign done    = done_q;
  assign result  = result_q;
  assign flag_z  = fz_q;
  assign flag_c  = fc_q;

endmodule
